// File: rtl/my_axi4_lite_pkg.sv
// Shared types for the command-driven AXI4-Lite master: response codes,
// FSM state encoding and the command record.
package my_axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } mst_cmd_state_t;

  // Widest supported address/data so one record type serves every build.
  localparam int CMD_ADDR_W_MAX = 32;
  localparam int CMD_DATA_W_MAX = 64;

  typedef struct packed {
    logic                        is_wr;
    logic [CMD_ADDR_W_MAX-1:0]   addr;
    logic [CMD_DATA_W_MAX-1:0]   wdata;
    logic [CMD_DATA_W_MAX/8-1:0] wstrb;
  } mst_cmd_t;

endpackage

// File: rtl/aix4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
interface aix4_lite_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport mst_port (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slv_port (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/my_axi4_lite_mst_cmd.sv
// Command-driven AXI4-Lite master: one single-beat read or write at a time,
// outcome returned on a valid/ready response port. All AXI outputs registered.
// Optional feature macro: MY_AXI4_LITE_MST_CMD_LAT_CNT_EN adds o_rsp_lat_cycles,
// the cycle count from command acceptance to the B/R handshake (saturating).
module my_axi4_lite_mst_cmd
  import my_axi4_lite_pkg::*;
#(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 4,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
  parameter int LAT_CNT_BIT_WIDTH        = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_sync_rst,
  input  logic                                  i_cmd_valid,
  output logic                                  o_cmd_ready,
  input  logic                                  i_cmd_is_wr,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                                  o_rsp_valid,
  input  logic                                  i_rsp_ready,
  output logic                                  o_rsp_is_wr,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                            o_rsp_resp,
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
  output logic [LAT_CNT_BIT_WIDTH-1:0]          o_rsp_lat_cycles,
`endif
  aix4_lite_if.mst_port                         if_m_axi4_lite
);

  localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int DW = AXI4_LITE_DATA_BIT_WIDTH;
  localparam int SW = AXI4_LITE_DATA_BIT_WIDTH / 8;

  // Reject unsupported parameter sets at elaboration.
  if (!(DW == 32 || DW == 64) || LAT_CNT_BIT_WIDTH < 1) begin : g_param_check
    $error("my_axi4_lite_mst_cmd: unsupported parameter set");
  end

  mst_cmd_state_t state_q, state_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic          arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_is_wr_q, rsp_is_wr_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_resp_q, rsp_resp_d;
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
  logic [LAT_CNT_BIT_WIDTH-1:0] lat_cnt_q, lat_cnt_d, rsp_lat_q, rsp_lat_d;

  function automatic logic [LAT_CNT_BIT_WIDTH-1:0] sat_inc(
    input logic [LAT_CNT_BIT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  assign o_cmd_ready = (state_q == IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_is_wr = rsp_is_wr_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
  assign o_rsp_lat_cycles = rsp_lat_q;
`endif

  assign if_m_axi4_lite.awaddr  = awaddr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.araddr  = araddr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.rready  = rready_q;

  // Next-state and next-output decode; every register holds unless a state acts on it.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_is_wr_d = rsp_is_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
    lat_cnt_d   = (state_q == IDLE || state_q == RSP) ? lat_cnt_q : sat_inc(lat_cnt_q);
    rsp_lat_d   = rsp_lat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
          lat_cnt_d = '0;
`endif
          if (i_cmd_is_wr) begin
            awaddr_d  = i_cmd_addr;
            wdata_d   = i_cmd_wdata;
            wstrb_d   = i_cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = i_cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        // AW and W complete independently; B is requested only after both.
        if (awvalid_q && if_m_axi4_lite.awready) awvalid_d = 1'b0;
        if (wvalid_q && if_m_axi4_lite.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (if_m_axi4_lite.bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_is_wr_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = if_m_axi4_lite.bresp;
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
          rsp_lat_d   = sat_inc(lat_cnt_q);
`endif
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && if_m_axi4_lite.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (if_m_axi4_lite.rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_is_wr_d = 1'b0;
          rsp_rdata_d = if_m_axi4_lite.rdata;
          rsp_resp_d  = if_m_axi4_lite.rresp;
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
          rsp_lat_d   = sat_inc(lat_cnt_q);
`endif
          state_d     = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_is_wr_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
      lat_cnt_q   <= '0;
      rsp_lat_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_is_wr_q <= rsp_is_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
      lat_cnt_q   <= lat_cnt_d;
      rsp_lat_q   <= rsp_lat_d;
`endif
    end
  end

endmodule

// File: tb/tb_my_axi4_lite_mst_cmd.sv
// Bench for my_axi4_lite_mst_cmd: a 4-register AXI4-Lite slave with scripted
// ready/response timing, a reference register model, and a response scoreboard.
module tb_my_axi4_lite_mst_cmd;
  import my_axi4_lite_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int LW = 16;
  localparam logic [DW-1:0] ERR_DATA = 32'h5A5A5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_is_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_is_wr;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
  logic [LW-1:0] rsp_lat;
`endif

  aix4_lite_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  my_axi4_lite_mst_cmd #(
    .AXI4_LITE_ADDR_BIT_WIDTH(AW),
    .AXI4_LITE_DATA_BIT_WIDTH(DW),
    .LAT_CNT_BIT_WIDTH(LW)
  ) dut (
    .i_clk(clk),
    .i_sync_rst(rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_is_wr(cmd_is_wr),
    .i_cmd_addr(cmd_addr),
    .i_cmd_wdata(cmd_wdata),
    .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_is_wr(rsp_is_wr),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_resp(rsp_resp),
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
    .o_rsp_lat_cycles(rsp_lat),
`endif
    .if_m_axi4_lite(axi)
  );

  // Slave behaviour per transaction: response code and handshake delays.
  typedef struct {
    logic [1:0] resp;
    int         da;   // AW (or AR) ready delay
    int         dw;   // W ready delay
    int         dx;   // B (or R) valid delay
  } plan_t;

  typedef struct packed {
    logic          is_wr;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  plan_t         plan_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem[4];
  logic [DW-1:0] slv_mem[4];
  int            checks = 0;
  int            failures = 0;
  int            hold_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_is_wr"}, rsp_is_wr, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_resp"}, rsp_resp, 0);
    check({tag, "_axi_valids"}, {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    check({tag, "_axi_readies"}, {axi.bready, axi.rready}, 0);
    check({tag, "_axi_payload"}, {axi.awaddr, axi.araddr, axi.wdata, axi.wstrb}, 0);
`ifdef MY_AXI4_LITE_MST_CMD_LAT_CNT_EN
    check({tag, "_rsp_lat"}, rsp_lat, 0);
`endif
  endtask

  // ---------------- slave responder ----------------
  task automatic slv_write();
    plan_t         p;
    int            n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    if (plan_q.size() == 0) begin
      check("wr_plan_missing", 1, 0);
      return;
    end
    p = plan_q.pop_front();
    n = (p.da > p.dw) ? p.da : p.dw;
    a = '0;
    d = '0;
    s = '0;
    for (int c = 0; c <= n; c++) begin
      axi.awready = (c == p.da);
      axi.wready  = (c == p.dw);
      if (c == p.da) a = axi.awaddr;
      if (c == p.dw) begin
        d = axi.wdata;
        s = axi.wstrb;
      end
      @(posedge clk); #1;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      check("awvalid_track", axi.awvalid, (c < p.da));
      check("wvalid_track", axi.wvalid, (c < p.dw));
    end
    check("bready_after_aw_w", axi.bready, 1);
    if (!p.resp[1]) begin
      for (int b = 0; b < SW; b++)
        if (s[b]) slv_mem[a[3:2]][8*b +: 8] = d[8*b +: 8];
    end
    for (int k = 0; k < p.dx; k++) begin
      @(posedge clk); #1;
      if (rst) return;
    end
    axi.bresp  = p.resp;
    axi.bvalid = 1'b1;
    @(posedge clk); #1;
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    check("rsp_valid_after_b", rsp_valid, 1);
    check("bready_drop", axi.bready, 0);
  endtask

  task automatic slv_read();
    plan_t         p;
    logic [AW-1:0] a;
    if (plan_q.size() == 0) begin
      check("rd_plan_missing", 1, 0);
      return;
    end
    p = plan_q.pop_front();
    a = '0;
    for (int c = 0; c <= p.da; c++) begin
      axi.arready = (c == p.da);
      if (c == p.da) a = axi.araddr;
      @(posedge clk); #1;
      axi.arready = 1'b0;
      check("arvalid_track", axi.arvalid, (c < p.da));
    end
    check("rready_after_ar", axi.rready, 1);
    for (int k = 0; k < p.dx; k++) begin
      @(posedge clk); #1;
      if (rst) return;
    end
    axi.rresp  = p.resp;
    axi.rdata  = p.resp[1] ? ERR_DATA : slv_mem[a[3:2]];
    axi.rvalid = 1'b1;
    @(posedge clk); #1;
    axi.rvalid = 1'b0;
    axi.rdata  = '0;
    axi.rresp  = 2'b00;
    check("rsp_valid_after_r", rsp_valid, 1);
    check("rready_drop", axi.rready, 0);
  endtask

  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (axi.awvalid || axi.wvalid) slv_write();
        else if (axi.arvalid)          slv_read();
      end
    end
  end

  // ---------------- response-port backpressure ----------------
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_cnt > 0) begin
        rsp_ready = 1'b0;
        hold_cnt--;
      end else begin
        rsp_ready = ($urandom % 4) != 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic prev_v, prev_r, hs_prev;
    exp_t prev_bus, cur, e;
    prev_v = 1'b0;
    prev_r = 1'b0;
    hs_prev = 1'b0;
    prev_bus = '0;
    forever begin
      @(negedge clk);
      cur.is_wr = rsp_is_wr;
      cur.rdata = rsp_rdata;
      cur.resp  = rsp_resp;
      if (rst) begin
        prev_v  = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) begin
          check("rsp_valid_drop", rsp_valid, 0);
          check("cmd_ready_after_rsp", cmd_ready, 1);
        end
        if (rsp_valid) begin
          check("cmd_ready_low_in_rsp", cmd_ready, 0);
          if (prev_v && !prev_r) check("rsp_stable", cur, prev_bus);
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_rsp", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("rsp_is_wr", rsp_is_wr, e.is_wr);
              check("rsp_rdata", rsp_rdata, e.rdata);
              check("rsp_resp", rsp_resp, e.resp);
            end
          end
        end
        prev_v   = rsp_valid;
        prev_r   = rsp_ready;
        prev_bus = cur;
        hs_prev  = rsp_valid && rsp_ready;
      end
    end
  end

  // ---------------- stimulus with reference model ----------------
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [SW-1:0] ws, input logic [1:0] resp,
                       input int da, input int dw, input int dx);
    plan_t p;
    exp_t  e;
    bit    acc;
    p.resp = resp;
    p.da   = da;
    p.dw   = wr ? dw : 0;
    p.dx   = dx;
    plan_q.push_back(p);
    // Register model: a write lands only on a non-error response; error reads return ERR_DATA.
    e.is_wr = wr;
    e.resp  = resp;
    if (wr) begin
      e.rdata = '0;
      if (!resp[1]) begin
        for (int b = 0; b < SW; b++)
          if (ws[b]) ref_mem[addr[3:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end else begin
      e.rdata = resp[1] ? ERR_DATA : ref_mem[addr[3:2]];
    end
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_is_wr = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    acc = 1'b0;
    for (int t = 0; t < 300 && !acc; t++) begin
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      $display("FAIL cmd_accept_timeout actual=not_accepted required=accepted");
      $fatal(1, "command never accepted");
    end
    check("cmd_ready_after_accept", cmd_ready, 0);
    if (wr) begin
      check("aw_w_valid_rise", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b110);
      check("awaddr", axi.awaddr, addr);
      check("wdata_wstrb", {axi.wdata, axi.wstrb}, {wd, ws});
    end else begin
      check("ar_valid_rise", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b001);
      check("araddr", axi.araddr, addr);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [1:0]    r;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_is_wr = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then read back, partial strobes
    issue(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, RESP_OKAY, 1, 1, 1);
    issue(1'b0, 4'h4, '0, '0, RESP_OKAY, 0, 0, 0);
    issue(1'b1, 4'h8, 32'h11223344, 4'hF, RESP_OKAY, 0, 0, 0);
    issue(1'b1, 4'h8, 32'hAABBCCDD, 4'h5, RESP_OKAY, 1, 0, 2);
    issue(1'b0, 4'h8, '0, '0, RESP_OKAY, 2, 0, 1);

    // AW/W ordering: AW first, W first, together
    issue(1'b1, 4'h0, 32'hCAFEF00D, 4'hF, RESP_OKAY, 0, 3, 1);
    issue(1'b1, 4'h0, 32'h0BADC0DE, 4'h3, RESP_OKAY, 3, 0, 0);
    issue(1'b1, 4'hC, 32'h12345678, 4'hF, RESP_OKAY, 2, 2, 0);
    issue(1'b0, 4'h0, '0, '0, RESP_OKAY, 1, 0, 0);

    // Error pass-through on both channels
    issue(1'b0, 4'h4, '0, '0, RESP_SLVERR, 1, 0, 2);
    issue(1'b1, 4'h4, 32'hFFFFFFFF, 4'hF, RESP_DECERR, 0, 0, 1);
    issue(1'b0, 4'h4, '0, '0, RESP_OKAY, 0, 0, 0);

    // Response backpressure held well beyond the response arrival
    hold_cnt = 20;
    issue(1'b0, 4'hC, '0, '0, RESP_OKAY, 0, 0, 0);
    issue(1'b1, 4'h8, 32'h55AA55AA, 4'hA, RESP_OKAY, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      a = AW'(($urandom % 4) << 2);
      r = ($urandom % 3 != 0) ? RESP_OKAY : 2'($urandom % 4);
      issue(1'($urandom % 2), a, $urandom, 4'($urandom), r,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset while waiting for B: no response, everything back to reset values
    issue(1'b1, 4'hC, 32'h01020304, 4'hF, RESP_OKAY, 0, 0, 40);
    for (int t = 0; t < 20 && !axi.bready; t++) begin
      @(posedge clk); #1;
    end
    check("reach_wr_resp", axi.bready, 1);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    repeat (5) @(negedge clk);
    check("no_rsp_after_rst", rsp_valid, 0);
    @(posedge clk); #1;
    issue(1'b0, 4'hC, '0, '0, RESP_OKAY, 0, 0, 0);

    for (int t = 0; t < 300 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
